// File: rtl/inst_fetch.sv
// inst_fetch: RV32 fetch stage issuing credit-limited imem requests into an in-order fetch buffer with redirect flush.
// Optional IF_MISALIGN_CHECK_EN traps misaligned redirect targets into an ERR state.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];
`ifdef IF_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif
  state_t state, state_nxt;
  logic [31:0] pc, target;
  logic [31:0] fifo_inst [FIFO_DEPTH];
  logic [31:0] fifo_pc [FIFO_DEPTH];
  logic [31:0] req_pc [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, qw_ptr, qr_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [CW:0] occ;
  logic gnt, rsp, drop, push, pop, pop_raw, credit;
  assign gnt = imem_req & imem_gnt;
  // Responses with nothing owed (e.g. straight after reset) are not ours.
  assign rsp = imem_rvalid & (outstanding != '0);
  assign drop = rsp & (drop_cnt != '0);
  assign push = rsp & ~drop & ~redirect_valid;
  assign pop_raw = inst_valid & inst_ready;
  assign pop = pop_raw & ~redirect_valid;
  // A slot freed by this cycle's pop is safe to reuse: the response is at least a cycle away.
  assign occ = {1'b0, count} + {1'b0, outstanding} - {{CW{1'b0}}, pop_raw};
  assign credit = occ < DEPTH_W;
`ifdef IF_MISALIGN_CHECK_EN
  assign target = redirect_pc;
  assign misalign_err = state == ERR;
`else
  assign target = redirect_pc & ~32'h3;
`endif
  assign imem_addr = pc;
  assign inst_valid = count != '0;
  assign inst = inst_valid ? fifo_inst[rd_ptr] : '0;
  assign inst_pc = inst_valid ? fifo_pc[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? FETCH : state;
`ifdef IF_MISALIGN_CHECK_EN
    if (redirect_valid && redirect_pc[1:0] != 2'b00) state_nxt = ERR;
`endif
    imem_req = state == FETCH && credit && !redirect_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      qw_ptr <= '0;
      qr_ptr <= '0;
    end else begin
      pc <= redirect_valid ? target : gnt ? pc + 32'd4 : pc;
      outstanding <= outstanding + CW'(gnt) - CW'(rsp);
      // Everything still owed after this cycle belongs to the old path.
      drop_cnt <= redirect_valid ? outstanding - CW'(rsp) : drop_cnt - CW'(drop);
      count <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
      wr_ptr <= redirect_valid ? '0 : wr_ptr + AW'(push);
      rd_ptr <= redirect_valid ? '0 : rd_ptr + AW'(pop);
      qw_ptr <= qw_ptr + AW'(gnt);
      qr_ptr <= qr_ptr + AW'(rsp);
    end
  end
  always_ff @(posedge clk) begin
    if (gnt) req_pc[qw_ptr] <= pc;
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr] <= req_pc[qr_ptr];
    end
  end
endmodule
